// File: rtl/pedal_sensor_cond.sv
// -----------------------------------------------------------------------------
// pedal_sensor_cond
//
// Conditions the crank-sensor inputs for the desired-drive computation.
// The asynchronous cadence pulse is synchronized, and its rising edges are
// counted over a fixed window. The result is reported as a saturated 5-bit
// cadence. A torque sample is taken on every cadence edge and folded into an
// exponential running average.
//
// Parameters
//   WIN_CYC    cadence window length in clock cycles (>= 4)
//   AVG_SHIFT  average weight: each new sample counts 1/2^AVG_SHIFT (1..8)
//   NP_THRESH  not_pedaling asserts while cadence < NP_THRESH
//
// Ports
//   clk           in   1   system clock
//   rst           in   1   synchronous, active-high reset
//   cadence_raw   in   1   asynchronous crank sensor pulse
//   torque        in  12   unsigned torque reading, stable at its source
//   avg_torque    out 12   running torque average
//   cadence       out  5   edges in the last completed window, saturated at 31
//   not_pedaling  out  1   high while cadence < NP_THRESH
//   valid         out  1   one-cycle pulse when cadence/not_pedaling update
// -----------------------------------------------------------------------------
module pedal_sensor_cond #(
   parameter int unsigned WIN_CYC   = 4096,
   parameter int unsigned AVG_SHIFT = 4,
   parameter int unsigned NP_THRESH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cadence_raw,
   input  logic [11:0] torque,
   output logic [11:0] avg_torque,
   output logic [4:0]  cadence,
   output logic        not_pedaling,
   output logic        valid
);

   localparam int unsigned     WIN_W    = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
   localparam int unsigned     ACC_W    = 12 + AVG_SHIFT;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
   localparam logic [5:0]      EDGE_SAT = 6'd32;

   // Synchronizer and edge detect
   logic s1;
   logic s2;
   logic s3;
   logic rise;

   // Window and edge counting
   logic [WIN_W-1:0] win_cnt;
   logic             close;
   logic [5:0]       edge_cnt;
   logic [4:0]       edge_clamped;

   // Torque average
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_next;

   // NOTE: s1/s2 form the two-flop synchronizer for the asynchronous pin. s3
   // only delays s2 for edge detection. Nothing but s1 may sample cadence_raw.
   // NOTE: every register uses non-blocking assignments, so all flops sample
   // the pre-edge values and the s1->s2->s3 shift behaves as a true pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= cadence_raw;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

   // Free-running window counter. It restarts from 0 out of reset, so a
   // reset mid-window begins a fresh full-length window.
   assign close = (win_cnt == WIN_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt <= '0;
      end else if (close) begin
         win_cnt <= '0;
      end else begin
         win_cnt <= win_cnt + 1'b1;
      end
   end

   // edge_cnt saturates at 32, one past the reportable maximum. This keeps the
   // clamp to 31 correct however many edges arrive in a window.
   assign edge_clamped = (edge_cnt > 6'd31) ? 5'd31 : edge_cnt[4:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt     <= '0;
         cadence      <= '0;
         not_pedaling <= 1'b1;
         valid        <= 1'b0;
      end else begin
         valid <= close;
         if (close) begin
            cadence      <= edge_clamped;
            not_pedaling <= (32'(edge_clamped) < NP_THRESH);
            // An edge in the closing cycle is not in this window's report.
            // It becomes the first edge of the next window.
            edge_cnt     <= rise ? 6'd1 : 6'd0;
         end else if (rise && (edge_cnt != EDGE_SAT)) begin
            edge_cnt <= edge_cnt + 6'd1;
         end
      end
   end

   // Exponential average: acc converges to torque << AVG_SHIFT, so acc can
   // never exceed 4095 << AVG_SHIFT and the update cannot overflow.
   assign acc_next = acc - (acc >> AVG_SHIFT) + ACC_W'(torque);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (rise) begin
         acc <= acc_next;
      end
   end

   assign avg_torque = acc[AVG_SHIFT +: 12];

endmodule

// File: tb/tb_pedal_sensor_cond.sv
// -----------------------------------------------------------------------------
// tb_pedal_sensor_cond
//
// Directed bench for pedal_sensor_cond with WIN_CYC = 128, AVG_SHIFT = 4 and
// NP_THRESH = 2. Inputs change 1 time unit after each rising edge, and outputs
// are sampled at the same point.
//
// Cycle bookkeeping: cyc counts clock edges since the last reset edge. A pulse
// raised just after edge c is counted at edge c+3. A count at edge e belongs
// to the window that reports at the first multiple of 128 that is > e.
// valid is therefore expected exactly when cyc is a non-zero multiple of 128.
// -----------------------------------------------------------------------------
module tb_pedal_sensor_cond;

   localparam int WIN = 128;

   logic        clk = 1'b0;
   logic        rst;
   logic        cadence_raw;
   logic [11:0] torque;
   logic [11:0] avg_torque;
   logic [4:0]  cadence;
   logic        not_pedaling;
   logic        valid;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model of the synchronizer and torque average
   logic        m_s1 = 1'b0;
   logic        m_s2 = 1'b0;
   logic        m_s3 = 1'b0;
   logic [15:0] m_acc = 16'h0;

   bit seen;

   pedal_sensor_cond #(
      .WIN_CYC  (WIN),
      .AVG_SHIFT(4),
      .NP_THRESH(2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cadence_raw (cadence_raw),
      .torque      (torque),
      .avg_torque  (avg_torque),
      .cadence     (cadence),
      .not_pedaling(not_pedaling),
      .valid       (valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock, step the model, then check avg_torque and valid.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_s1  = 1'b0;
         m_s2  = 1'b0;
         m_s3  = 1'b0;
         m_acc = 16'h0;
         cyc   = 0;
      end else begin
         if (m_s2 && !m_s3) begin
            m_acc = m_acc - (m_acc >> 4) + {4'h0, torque};
         end
         m_s3 = m_s2;
         m_s2 = m_s1;
         m_s1 = cadence_raw;
         cyc++;
      end
      #1;
      check("avg_model", avg_torque, m_acc[15:4]);
      check("valid_timing", valid, (cyc != 0) && (cyc % WIN == 0));
   endtask

   task automatic pulse(input int hi, input int lo);
      cadence_raw = 1'b1;
      repeat (hi) tick();
      cadence_raw = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic wait_valid(input int budget);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (valid === 1'b1) seen = 1'b1;
      end
      check("valid_seen", seen, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_avg"}, avg_torque, 12'h000);
      check({tag, "_cadence"}, cadence, 5'd0);
      check({tag, "_np"}, not_pedaling, 1'b1);
      check({tag, "_valid"}, valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      cadence_raw = 1'b1;
      torque      = 12'h800;

      // Reset with the pin toggling
      tick();
      check_reset_outputs("reset0");
      cadence_raw = 1'b0;
      tick();
      check_reset_outputs("reset1");
      rst = 1'b0;

      // First window: nothing counted
      wait_valid(200);
      check("first_valid_cyc", cyc, 128);
      check("w1_cadence", cadence, 5'd0);
      check("w1_np", not_pedaling, 1'b1);

      // Window 2: five 4/4 pulses; the first two updates are checked directly
      cadence_raw = 1'b1;
      repeat (3) tick();
      check("avg_first_edge", avg_torque, 12'h080);
      tick();
      cadence_raw = 1'b0;
      repeat (4) tick();
      cadence_raw = 1'b1;
      repeat (3) tick();
      check("avg_second_edge", avg_torque, 12'h0F8);
      tick();
      cadence_raw = 1'b0;
      repeat (4) tick();
      repeat (3) pulse(4, 4);
      wait_valid(200);
      check("w2_cyc", cyc, 256);
      check("w2_cadence", cadence, 5'd5);
      check("w2_np", not_pedaling, 1'b0);

      // Window 3: 32 edges saturate; 8 more spill into window 4
      repeat (32) pulse(2, 2);
      check("w3_valid", valid, 1'b1);
      check("w3_cadence_sat", cadence, 5'd31);
      check("w3_np", not_pedaling, 1'b0);
      repeat (8) pulse(2, 2);
      wait_valid(200);
      check("w4_cyc", cyc, 512);
      check("w4_cadence", cadence, 5'd8);

      // Window 5: single pulse, below threshold
      pulse(4, 4);
      wait_valid(200);
      check("w5_cyc", cyc, 640);
      check("w5_cadence", cadence, 5'd1);
      check("w5_np", not_pedaling, 1'b1);

      // 160 more edges (206 total) at constant torque
      repeat (160) pulse(2, 2);
      check("w10_valid", valid, 1'b1);
      check("w10_cadence", cadence, 5'd31);
      check("avg_settled", (avg_torque >= 12'h7FE) && (avg_torque <= 12'h800), 1);

      // Window boundary, with a new torque value for the model
      torque = 12'h3A5;
      repeat (3) pulse(4, 4);
      repeat (101) tick();
      cadence_raw = 1'b1;
      repeat (3) tick();
      check("boundary_cyc", cyc, 1408);
      check("boundary_valid", valid, 1'b1);
      check("boundary_cadence", cadence, 5'd3);
      check("boundary_np", not_pedaling, 1'b0);
      tick();
      cadence_raw = 1'b0;
      repeat (4) tick();
      pulse(4, 4);
      wait_valid(200);
      check("w12_cyc", cyc, 1536);
      check("w12_cadence", cadence, 5'd2);

      // Reset at cycle 60 of a window holding 10 edges
      repeat (10) pulse(2, 2);
      repeat (20) tick();
      rst = 1'b1;
      tick();
      check_reset_outputs("midreset0");
      tick();
      check_reset_outputs("midreset1");
      rst = 1'b0;
      cadence_raw = 1'b1;
      repeat (3) tick();
      check("avg_after_reset", avg_torque, 12'h03A);
      tick();
      cadence_raw = 1'b0;
      repeat (4) tick();
      repeat (2) pulse(4, 4);
      wait_valid(200);
      check("post_reset_cyc", cyc, 128);
      check("post_reset_cadence", cadence, 5'd3);
      check("post_reset_np", not_pedaling, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
